// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing a single four-function ALU; one operation in flight,
// result held in a registered response slot until the consumer accepts it.
module alu_share_arbiter #(
  parameter int WIDTH      = 18,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d, last_q, last_d, zero_q, zero_d;
  logic             grant0, grant1;
  logic [WIDTH-1:0] alu_y;

  // Ties go to whoever was not served last, unless requester 0 is hard-wired to win.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || FIXED_PRIO || last_q))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  always_comb begin
    alu_y = '0;
    case (op_q)
      2'b00: alu_y = a_q + b_q;
      2'b01: alu_y = a_q & b_q;
      2'b10: alu_y = ~(a_q & b_q);
      2'b11: alu_y = ~(a_q | b_q);
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    data_d  = data_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = req0_op;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = EXEC;
        end else if (grant1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = req1_op;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_y;
        zero_d  = (alu_y == '0);
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      last_q  <= last_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one round-robin and one fixed-priority instance
// driven by the same stimulus, checked against hand-computed values.
module tb_alu_share_arbiter;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, rsp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;

  logic         rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_zero, rr_busy;
  logic [W-1:0] rr_rsp_data;
  logic         fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_zero, fp_busy;
  logic [W-1:0] fp_rsp_data;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b0)) dutRr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id),
    .rsp_data(rr_rsp_data), .rsp_zero(rr_rsp_zero), .busy(rr_busy)
  );

  alu_share_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b1)) dutFp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_data(fp_rsp_data), .rsp_zero(fp_rsp_zero), .busy(fp_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One complete single-requester transaction on the round-robin instance, rsp_ready held high.
  task automatic applyStimulus(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] op, input logic [W-1:0] expData,
                               input logic expZero, input string tag);
    @(posedge clk); #1;
    if (id == 1'b0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, ".ready"}, id ? rr_req1_ready : rr_req0_ready, 1);
    checkOutput({tag, ".otherReady"}, id ? rr_req0_ready : rr_req1_ready, 0);
    checkOutput({tag, ".idleBusy"}, rr_busy, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".execBusy"}, rr_busy, 1);
    checkOutput({tag, ".execValid"}, rr_rsp_valid, 0);
    @(negedge clk);
    checkOutput({tag, ".rspValid"}, rr_rsp_valid, 1);
    checkOutput({tag, ".rspData"}, rr_rsp_data, expData);
    checkOutput({tag, ".rspZero"}, rr_rsp_zero, expZero);
    checkOutput({tag, ".rspId"}, rr_rsp_id, id);
    checkOutput({tag, ".rspBusy"}, rr_busy, 1);
    @(negedge clk);
    checkOutput({tag, ".doneBusy"}, rr_busy, 0);
    checkOutput({tag, ".doneValid"}, rr_rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_a = '0; req1_b = '0; req1_op = 2'b00;
    $display("[TB] start");
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.rspValid", rr_rsp_valid, 0);
    checkOutput("reset.rspData", rr_rsp_data, 0);
    checkOutput("reset.rspZero", rr_rsp_zero, 0);
    checkOutput("reset.rspId", rr_rsp_id, 0);
    checkOutput("reset.busy", rr_busy, 0);
    checkOutput("reset.fpBusy", fp_busy, 0);
    rst = 1'b0;

    applyStimulus(1'b0, 18'h00005, 18'h00003, 2'b00, 18'h00008, 1'b0, "single");

    // Carry out of bit 17 is dropped: 0x3F0F0 + 0x0FF00 = 0x4EFF0 -> 0x0EFF0.
    applyStimulus(1'b1, 18'h3F0F0, 18'h0FF00, 2'b00, 18'h0EFF0, 1'b0, "opAdd");
    applyStimulus(1'b1, 18'h3F0F0, 18'h0FF00, 2'b01, 18'h0F000, 1'b0, "opAnd");
    applyStimulus(1'b1, 18'h3F0F0, 18'h0FF00, 2'b10, 18'h30FFF, 1'b0, "opNand");
    applyStimulus(1'b1, 18'h3F0F0, 18'h0FF00, 2'b11, 18'h0000F, 1'b0, "opNor");

    applyStimulus(1'b0, 18'h3FFFF, 18'h00001, 2'b00, 18'h00000, 1'b1, "overflow");

    // Reset asserted asynchronously while an operation is in EXEC.
    @(posedge clk); #1;
    req0_a = 18'h00007; req0_b = 18'h00001; req0_op = 2'b00; req0_valid = 1'b1;
    @(negedge clk);
    checkOutput("midRst.ready", rr_req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #1;
    checkOutput("midRst.execBusy", rr_busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("midRst.rspValid", rr_rsp_valid, 0);
    checkOutput("midRst.busy", rr_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("midRst.noRsp%0d", k), rr_rsp_valid, 0);
      checkOutput($sformatf("midRst.idle%0d", k), rr_busy, 0);
    end

    // Both requesters held valid for four operations.
    @(posedge clk); #1;
    req0_a = 18'h00001; req0_b = 18'h00002; req0_op = 2'b00;
    req1_a = 18'h00010; req1_b = 18'h00020; req1_op = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr%0d.ready0", k), rr_req0_ready, (k % 2 == 0));
      checkOutput($sformatf("rr%0d.ready1", k), rr_req1_ready, (k % 2 == 1));
      checkOutput($sformatf("fp%0d.ready0", k), fp_req0_ready, 1);
      checkOutput($sformatf("fp%0d.ready1", k), fp_req1_ready, 0);
      @(negedge clk);
      checkOutput($sformatf("rr%0d.execReady0", k), rr_req0_ready, 0);
      checkOutput($sformatf("rr%0d.execReady1", k), rr_req1_ready, 0);
      @(negedge clk);
      checkOutput($sformatf("rr%0d.rspId", k), rr_rsp_id, k % 2);
      checkOutput($sformatf("rr%0d.rspData", k), rr_rsp_data, (k % 2 == 1) ? 32'h30 : 32'h3);
      checkOutput($sformatf("fp%0d.rspId", k), fp_rsp_id, 0);
      checkOutput($sformatf("fp%0d.rspData", k), fp_rsp_data, 32'h3);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: response held five cycles while requester 1 waits.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_a = 18'h12345; req0_b = 18'h00111; req0_op = 2'b01; req0_valid = 1'b1;
    @(negedge clk);
    checkOutput("bp.ready0", rr_req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    req1_a = 18'h00002; req1_b = 18'h00003; req1_op = 2'b00; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d.rspValid", k), rr_rsp_valid, 1);
      checkOutput($sformatf("bp%0d.rspData", k), rr_rsp_data, 32'h00101);
      checkOutput($sformatf("bp%0d.rspId", k), rr_rsp_id, 0);
      checkOutput($sformatf("bp%0d.ready1", k), rr_req1_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.lastRspValid", rr_rsp_valid, 1);
    checkOutput("bp.lastReady1", rr_req1_ready, 0);
    @(negedge clk);
    checkOutput("bp.afterReady1", rr_req1_ready, 1);
    checkOutput("bp.afterRspValid", rr_rsp_valid, 0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp.req1Busy", rr_busy, 1);
    @(negedge clk);
    checkOutput("bp.req1Data", rr_rsp_data, 32'h5);
    checkOutput("bp.req1Id", rr_rsp_id, 1);
    @(negedge clk);
    checkOutput("bp.finalBusy", rr_busy, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
